// File: rtl/reg_chain_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_chain_rr_arbiter_pkg
// Description : Shared helpers for the round-robin register-chain arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_chain_rr_arbiter_pkg;

  // Requester tag width: ceil(log2(n)), never narrower than one bit.
  function automatic int tag_width_f(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

  // Round-robin distance of candidate j behind the last grant (0 = next in line).
  function automatic int rr_distance_f(input int j, input int last, input int n);
    int d;
    d = j - last - 1;
    if (d < 0) begin
      d = d + n;
    end
    return d;
  endfunction

endpackage : reg_chain_rr_arbiter_pkg
`default_nettype wire

// File: rtl/reg_chain_rr_arbiter_stage.sv
`default_nettype none
// ============================================================================
// Module      : reg_chain_stage
// Description : One {vld, tag, data} pipeline register with load enable.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_chain_stage #(
  parameter int DATA_WIDTH = 8,
  parameter int TAG_WIDTH  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  d_vld,
  input  logic [TAG_WIDTH-1:0]  d_tag,
  input  logic [DATA_WIDTH-1:0] d_data,
  output logic                  q_vld,
  output logic [TAG_WIDTH-1:0]  q_tag,
  output logic [DATA_WIDTH-1:0] q_data
);

  typedef struct packed {
    logic                  vld;
    logic [TAG_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] data;
  } stage_t;

  localparam stage_t C_STAGE_RST = '0;

  stage_t r_stage;

  // A bubble only clears the valid flag; payload is kept to avoid needless toggling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stage <= C_STAGE_RST;
    end else if (en) begin
      r_stage.vld <= d_vld;
      if (d_vld) begin
        r_stage.tag  <= d_tag;
        r_stage.data <= d_data;
      end
    end
  end

  assign q_vld  = r_stage.vld;
  assign q_tag  = r_stage.tag;
  assign q_data = r_stage.data;

endmodule : reg_chain_stage
`default_nettype wire

// File: rtl/reg_chain_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : reg_chain_rr_arbiter
// Description : Round-robin arbiter feeding a shared bubble-collapsing register chain.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_chain_rr_arbiter
  import reg_chain_rr_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 2,
  parameter int REQ_CNT    = 2,
  parameter int TAG_WIDTH  = tag_width_f(REQ_CNT)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [REQ_CNT*DATA_WIDTH-1:0] in_data,
  input  logic [REQ_CNT-1:0]            in_vld,
  output logic [REQ_CNT-1:0]            in_rd,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [TAG_WIDTH-1:0]          out_tag,
  output logic                          out_vld,
  input  logic                          out_rd
);

  localparam logic [TAG_WIDTH-1:0] C_GRANT_RST = TAG_WIDTH'(REQ_CNT - 1);

  logic [DEPTH-1:0]      w_stage_vld;
  logic [TAG_WIDTH-1:0]  w_stage_tag  [DEPTH];
  logic [DATA_WIDTH-1:0] w_stage_data [DEPTH];
  logic [DEPTH-1:0]      w_d_vld;
  logic [TAG_WIDTH-1:0]  w_d_tag      [DEPTH];
  logic [DATA_WIDTH-1:0] w_d_data     [DEPTH];
  logic [DEPTH-1:0]      w_rdy;

  logic [TAG_WIDTH-1:0]  r_last_grant;
  logic [TAG_WIDTH-1:0]  w_winner;
  logic                  w_found;
  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_sel_data;

  // Ready chain: an empty stage always accepts, so bubbles collapse.
  always_comb begin
    w_rdy = '0;
    w_rdy[DEPTH-1] = out_rd | ~w_stage_vld[DEPTH-1];
    for (int i = DEPTH - 2; i >= 0; i--) begin
      w_rdy[i] = w_rdy[i+1] | ~w_stage_vld[i];
    end
  end

  // Valid requester with the smallest round-robin distance wins.
  always_comb begin
    int best;
    int d;
    w_found  = 1'b0;
    w_winner = '0;
    best     = REQ_CNT;
    d        = 0;
    for (int j = 0; j < REQ_CNT; j++) begin
      d = rr_distance_f(j, int'(r_last_grant), REQ_CNT);
      if (in_vld[j] && (d < best)) begin
        best     = d;
        w_winner = TAG_WIDTH'(j);
        w_found  = 1'b1;
      end
    end
  end

  always_comb begin
    w_sel_data = '0;
    for (int j = 0; j < REQ_CNT; j++) begin
      if (w_winner == TAG_WIDTH'(j)) begin
        w_sel_data = in_data[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Ready is withheld while reset is asserted so nothing is handshaken into a clearing chain.
  assign w_accept = w_found & w_rdy[0] & ~rst;

  always_comb begin
    in_rd = '0;
    for (int j = 0; j < REQ_CNT; j++) begin
      in_rd[j] = w_accept & (w_winner == TAG_WIDTH'(j));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= C_GRANT_RST;
    end else if (w_accept) begin
      r_last_grant <= w_winner;
    end
  end

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      if (i == 0) begin : g_head
        assign w_d_vld[i]  = w_accept;
        assign w_d_tag[i]  = w_winner;
        assign w_d_data[i] = w_sel_data;
      end else begin : g_link
        assign w_d_vld[i]  = w_stage_vld[i-1];
        assign w_d_tag[i]  = w_stage_tag[i-1];
        assign w_d_data[i] = w_stage_data[i-1];
      end

      reg_chain_stage #(
        .DATA_WIDTH (DATA_WIDTH),
        .TAG_WIDTH  (TAG_WIDTH)
      ) u_stage (
        .clk    (clk),
        .rst    (rst),
        .en     (w_rdy[i]),
        .d_vld  (w_d_vld[i]),
        .d_tag  (w_d_tag[i]),
        .d_data (w_d_data[i]),
        .q_vld  (w_stage_vld[i]),
        .q_tag  (w_stage_tag[i]),
        .q_data (w_stage_data[i])
      );
    end
  endgenerate

  assign out_vld  = w_stage_vld[DEPTH-1];
  assign out_tag  = w_stage_tag[DEPTH-1];
  assign out_data = w_stage_data[DEPTH-1];

endmodule : reg_chain_rr_arbiter
`default_nettype wire
